// File: rtl/cpu_run_pkg.sv
// Shared state encoding and default widths for the CPU run sequencer.
package cpu_run_pkg;

    localparam int DEF_NUM_CORES  = 1;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_RST_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } run_state_t;

endpackage

// File: rtl/cpu_run_sequencer_if.sv
// Host/core-side signal bundle of the run sequencer; the sequencer takes the slave side.
interface cpu_run_sequencer_if
    import cpu_run_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W
);
    logic                        start;
    logic [CNT_W-1:0]            timeout_cycles;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES*DATA_W-1:0] core_data;
    logic                        core_rst;
    logic                        core_enable;
    logic                        busy;
    logic                        done;
    logic                        timed_out;
    logic [NUM_CORES-1:0]        done_mask;
    logic [NUM_CORES*DATA_W-1:0] result;
    logic [CNT_W-1:0]            cycle_count;

    modport master (
        output start, timeout_cycles, core_done, core_data,
        input  core_rst, core_enable, busy, done, timed_out, done_mask, result, cycle_count
    );

    modport slave (
        input  start, timeout_cycles, core_done, core_data,
        output core_rst, core_enable, busy, done, timed_out, done_mask, result, cycle_count
    );
endinterface

// File: rtl/run_capture_lane.sv
// One core's result latch: the first done indication while capture is enabled wins.
module run_capture_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              capture_en_i,
    input  logic              done_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              captured_o,
    output logic [DATA_W-1:0] data_o
);
    logic              flag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            flag_q <= 1'b0;
            data_q <= '0;
        end else if (capture_en_i && done_in && !flag_q) begin
            flag_q <= 1'b1;
            data_q <= data_in;
        end
    end

    assign captured_o = flag_q;
    assign data_o     = data_q;
endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller: reset hold, one-cycle enable, run-cycle count, per-core result
// capture, and finish on all-done or watchdog expiry.
module cpu_run_sequencer
    import cpu_run_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    cpu_run_sequencer_if.slave  bus
);
    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

    run_state_t            state_q, state_d;
    logic [7:0]            rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]      timeout_q, timeout_d;
    logic [CNT_W-1:0]      cycle_inc;
    logic                  timed_out_q, timed_out_d;
    logic                  core_rst_q, core_enable_q, done_q, busy_q;
    logic                  lane_clear, capture_en;
    logic [NUM_CORES-1:0]  lane_flags, mask_next;
    logic [NUM_CORES*DATA_W-1:0] lane_data;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        run_capture_lane #(.DATA_W(DATA_W)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .clear_i      (lane_clear),
            .capture_en_i (capture_en),
            .done_in      (bus.core_done[i]),
            .data_in      (bus.core_data[i*DATA_W +: DATA_W]),
            .captured_o   (lane_flags[i]),
            .data_o       (lane_data[i*DATA_W +: DATA_W])
        );
    end

    assign cycle_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    assign mask_next = lane_flags | bus.core_done;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        timed_out_d   = timed_out_q;
        lane_clear    = 1'b0;
        capture_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RESET;
                    rst_cnt_d   = RST_LOAD;
                    timed_out_d = 1'b0;
                    lane_clear  = 1'b1;
                end
            end
            RESET: begin
                if (rst_cnt_q == 8'd0) state_d = ARM;
                else                   rst_cnt_d = rst_cnt_q - 8'd1;
            end
            ARM: begin
                cycle_count_d = '0;
                timeout_d     = bus.timeout_cycles;
                state_d       = RUN;
            end
            RUN: begin
                capture_en    = 1'b1;
                cycle_count_d = cycle_inc;
                // All-done wins over a watchdog hit in the same cycle
                if (&mask_next) begin
                    state_d = FINISH;
                end else if (timeout_q != '0 && cycle_inc == timeout_q) begin
                    state_d     = FINISH;
                    timed_out_d = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            timeout_q     <= '0;
            timed_out_q   <= 1'b0;
            core_rst_q    <= 1'b0;
            core_enable_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            timed_out_q   <= timed_out_d;
            core_rst_q    <= (state_d == RESET);
            core_enable_q <= (state_d == ARM);
            done_q        <= (state_d == FINISH);
            busy_q        <= (state_d != IDLE);
        end
    end

    // Cores stay in reset while the sequencer itself is held in reset
    assign bus.core_rst    = rst | core_rst_q;
    assign bus.core_enable = core_enable_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.done_mask   = lane_flags;
    assign bus.result      = lane_data;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: doc/cpu_run_sequencer.md
# cpu_run_sequencer

Synthesisable run controller for one or more `cpu` cores; it replaces hand-timed reset/enable pulses with a single parametrised sequence. On a `start` request it holds the cores in reset for a programmable number of cycles, then issues a one-cycle enable pulse. It counts run cycles, captures each core's result on its first done indication, and ends on all-done or watchdog timeout. It sits between the top-level harness (or host interface) and the core array.

## Interface
- `NUM_CORES`, 1: number of cores sequenced in lock-step.
- `DATA_W`, 16: per-core result width.
- `CNT_W`, 32: cycle counter and timeout width.
- `RST_CYCLES`, 4: cycles `core_rst` is held; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `timeout_cycles`  in  CNT_W  watchdog limit; 0 disables the watchdog. Sampled in ARM.
- `core_done`  in  NUM_CORES  per-core completion level.
- `core_data`  in  NUM_CORES*DATA_W  per-core result; lane i occupies bits [i*DATA_W +: DATA_W].
- `core_rst`  out  1  reset to cores, active-high.
- `core_enable`  out  1  one-cycle start pulse to cores.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at sequence end.
- `timed_out`  out  1  sticky; set at end if the watchdog fired.
- `done_mask`  out  NUM_CORES  lanes whose result was captured.
- `result`  out  NUM_CORES*DATA_W  captured results.
- `cycle_count`  out  CNT_W  RUN cycles elapsed; saturates at all-ones.

## Operation
- States: IDLE, RESET, ARM, RUN, FINISH.
- IDLE → RESET on `start`=1.
  - On entry: `done_mask`, `result` and `timed_out` are cleared.
  - Reset counter loaded with RST_CYCLES-1.
- RESET:
  - `core_rst`=1.
  - Counter decrements each cycle; at 0 → ARM.
- ARM:
  - `core_enable`=1 for exactly this cycle.
  - `cycle_count` cleared; `timeout_cycles` latched.
  - → RUN.
- RUN:
  - `cycle_count` increments each cycle, saturating at all-ones.
  - For each lane i with `core_done[i]`=1 and `done_mask[i]`=0: `result[i]` ← `core_data[i]` and `done_mask[i]` ← 1.
  - Later changes on a captured lane are ignored (first-capture wins).
  - All-done: if the next `done_mask` is all ones → FINISH.
  - Timeout: otherwise, if the latched timeout is non-zero and the next `cycle_count` equals it → FINISH with `timed_out` ← 1.
  - All-done has priority over timeout in the same cycle; `timed_out` then stays 0.
- FINISH:
  - `done`=1 for one cycle.
  - → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `result`, `done_mask`, `timed_out` and `cycle_count` hold their values in IDLE until the next `start`.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - `core_rst`=1 while `rst` is high, 0 after release.
  - `core_enable`, `done`, `busy`, `timed_out`, `done_mask`, `result`, `cycle_count` all 0.
- `rst` asserted mid-run aborts immediately; no `done` pulse is emitted.
- Cycle schedule, with `start` sampled at edge t:
  - `core_rst` high for cycles t+1 .. t+RST_CYCLES.
  - `core_enable` high in cycle t+RST_CYCLES+1.
  - RUN begins at cycle t+RST_CYCLES+2.
- A core asserting `core_done` in RUN cycle k (first RUN cycle = 1):
  - is captured at the end of cycle k;
  - makes `cycle_count`=k visible in cycle k+1;
  - produces the FINISH (`done`) pulse in cycle k+1 if it was the last lane.
- Timeout N: FINISH occurs in RUN cycle N+1, with `cycle_count`=N.
- `core_done` asserted during RESET or ARM is ignored; capture happens only in RUN.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `cpu_run_pkg`: state encoding constants (IDLE=0, RESET=1, ARM=2, RUN=3, FINISH=4; 3-bit) and the default widths.
- Sub-module `run_capture_lane` (DATA_W), one instance per core.
  - Inputs: `clk`, `rst`, clear, capture_en, `done_in`, `data_in`.
  - Outputs: captured flag and data register.
- Top level holds the FSM, reset counter, cycle counter and watchdog compare.

## Test plan
- NUM_CORES=1, RST_CYCLES=4: `start` at edge 10 → `core_rst` high cycles 11-14, `core_enable` high cycle 15 only, `busy` high from cycle 11.
- `core_done` rises in RUN cycle 7 with `core_data`=16'hBEEF → `result`=16'hBEEF, `done_mask`=1, `cycle_count`=7, `done` pulse, `timed_out`=0.
- `timeout_cycles`=20 with `core_done` never asserted → `done` in RUN cycle 21, `timed_out`=1, `cycle_count`=20, `done_mask`=0.
- NUM_CORES=3: lanes finish at cycles 3, 9, 5 with data 1, 2, 3 → `result`={3,2,1} packed, `done` after cycle 9; a lane-0 data change at cycle 6 is ignored.
- All-done coincides with the timeout cycle (`timeout_cycles`=5, last done at cycle 5) → `timed_out`=0. Separately, `start` pulsed during RUN has no effect.
- `rst` asserted in RUN cycle 4 → all outputs return to reset values immediately, no `done`. The next `start` runs a clean sequence.
